// File: rtl/assoc_cache_host_if.sv
// Request/response bus of the set-associative cache host.
// The master drives requests and flush; the slave (cache) returns responses and stats.
interface assoc_cache_host_if #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 4,
    parameter int IDX_W      = 3
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic [IDX_W-1:0]      req_index;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  flush;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_hit;
    logic                  busy;
    logic [15:0]           hit_count;
    logic [15:0]           miss_count;

    modport master (
        output req_valid, req_write, req_tag, req_index, req_wdata, flush,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, busy, hit_count, miss_count
    );

    modport slave (
        input  req_valid, req_write, req_tag, req_index, req_wdata, flush,
        output req_ready, rsp_valid, rsp_data, rsp_hit, busy, hit_count, miss_count
    );
endinterface

// File: rtl/assoc_cache_host.sv
// Set-associative cache host: one request per 3 cycles (IDLE->LOOKUP->RESPOND),
// round-robin victim on full sets, sequential per-set flush, saturating hit/miss stats.
module assoc_cache_host #(
    parameter int NUM_SETS   = 8,
    parameter int NUM_WAYS   = 2,
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    assoc_cache_host_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND, FLUSH} state_t;

    typedef struct packed {
        logic                  write;
        logic [TAG_WIDTH-1:0]  tag;
        logic [IDX_W-1:0]      idx;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t state_q, state_d;
    req_t   req_q;

    logic [NUM_SETS-1:0][NUM_WAYS-1:0]                 valid_q;
    logic [NUM_SETS-1:0][WAY_W-1:0]                    rr_q;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_WIDTH-1:0]  tag_q;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][DATA_WIDTH-1:0] data_q;

    logic [IDX_W-1:0]      flush_idx_q;
    logic [15:0]           hit_cnt, miss_cnt;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_hit_q;

    logic [NUM_WAYS-1:0] hit_vec;
    logic                hit, any_inv, accept, flush_last;
    logic [WAY_W-1:0]    hit_way, inv_way, victim, rr_next;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign hit_vec[w] = valid_q[req_q.idx][w] && (tag_q[req_q.idx][w] == req_q.tag);
    end

    // Descending scan so the lowest-numbered matching / invalid way wins.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        any_inv = 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (!valid_q[req_q.idx][w]) begin
                inv_way = WAY_W'(w);
                any_inv = 1'b1;
            end
        end
    end

    assign hit        = |hit_vec;
    assign victim     = any_inv ? inv_way : rr_q[req_q.idx];
    assign rr_next    = (rr_q[req_q.idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[req_q.idx] + 1'b1;
    assign flush_last = (flush_idx_q == IDX_W'(NUM_SETS - 1));

    assign bus.req_ready  = (state_q == IDLE) && !bus.flush && !rst;
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.busy       = (state_q != IDLE);
    assign bus.rsp_valid  = (state_q == RESPOND);
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.flush)          state_d = FLUSH;
                else if (bus.req_valid) state_d = LOOKUP;
            end
            LOOKUP:  state_d = RESPOND;
            RESPOND: state_d = IDLE;
            FLUSH:   if (flush_last) state_d = RESPOND;
            default: state_d = IDLE;
        endcase
    end

    // Control state, valid bits, pointers, stats and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            rr_q        <= '0;
            flush_idx_q <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            rsp_data_q  <= '0;
            rsp_hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: flush_idx_q <= '0;
                LOOKUP: begin
                    if (hit) begin
                        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                    end else begin
                        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                    end
                    rsp_hit_q  <= hit;
                    rsp_data_q <= (!req_q.write && hit) ? data_q[req_q.idx][hit_way] : '0;
                    if (req_q.write && !hit) begin
                        valid_q[req_q.idx][victim] <= 1'b1;
                        if (!any_inv) rr_q[req_q.idx] <= rr_next;
                    end
                end
                FLUSH: begin
                    valid_q[flush_idx_q] <= '0;
                    rr_q[flush_idx_q]    <= '0;
                    flush_idx_q          <= flush_idx_q + 1'b1;
                    if (flush_last) begin
                        rsp_hit_q  <= 1'b0;
                        rsp_data_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays and the request latch carry no reset; reset only blocks updates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                req_q <= '{write: bus.req_write, tag: bus.req_tag,
                           idx: bus.req_index, wdata: bus.req_wdata};
            end
            if (state_q == LOOKUP && req_q.write) begin
                if (hit) begin
                    data_q[req_q.idx][hit_way] <= req_q.wdata;
                end else begin
                    data_q[req_q.idx][victim] <= req_q.wdata;
                    tag_q[req_q.idx][victim]  <= req_q.tag;
                end
            end
        end
    end
endmodule
